scarv_soc_periph_router: RTL and testbench

Parametrised address-decoding router between the core-complex external memory interface and `NUM_DEV` peripheral slots. It generalises the fixed UART/GPIO dispatch to N devices with per-slot base/mask decode. It tracks one outstanding transaction, returns an error response for unmapped addresses, and has an optional bus timeout. It sits in the peripheral subsystem, between the CCX external port and the peripheral instances.

---
 rtl/scarv_soc_periph_router.sv | 189 ++++++++++++++++++
 tb/tb_scarv_soc_periph_router.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/scarv_soc_periph_router.sv
// Address-decoding router from the CCX external port to NUM_DEV peripheral slots, one transaction in flight.
// Optional per-phase bus timeout enabled by defining SCARV_SOC_PERIPH_ROUTER_TIMEOUT_EN.
module scarv_soc_periph_router #(
  parameter int unsigned               NUM_DEV  = 4,
  parameter logic [32*NUM_DEV-1:0]     DEV_BASE = {32'h1000_3000, 32'h1000_2000, 32'h1000_1000, 32'h1000_0000},
  parameter logic [32*NUM_DEV-1:0]     DEV_MASK = {NUM_DEV{32'hFFFF_F000}},
  parameter int unsigned               TIMEOUT  = 255
) (
  input  logic                     f_clk,
  input  logic                     g_resetn,
  input  logic                     h_req,
  output logic                     h_gnt,
  input  logic                     h_wen,
  input  logic [3:0]               h_strb,
  input  logic [31:0]              h_addr,
  input  logic [31:0]              h_wdata,
  output logic                     h_recv,
  input  logic                     h_ack,
  output logic                     h_error,
  output logic [31:0]              h_rdata,
  output logic [NUM_DEV-1:0]       d_req,
  input  logic [NUM_DEV-1:0]       d_gnt,
  output logic                     d_wen,
  output logic [3:0]               d_strb,
  output logic [31:0]              d_addr,
  output logic [31:0]              d_wdata,
  input  logic [NUM_DEV-1:0]       d_recv,
  output logic [NUM_DEV-1:0]       d_ack,
  input  logic [NUM_DEV-1:0]       d_error,
  input  logic [32*NUM_DEV-1:0]    d_rdata
);

  localparam int SW = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;

  if (NUM_DEV < 1 || NUM_DEV > 16 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_chk
    $error("scarv_soc_periph_router: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state_q;
  logic                gnt_q, live_q, recv_q, error_q, wen_q;
  logic [31:0]         rdata_q, addr_q, wdata_q;
  logic [3:0]          strb_q;
  logic [NUM_DEV-1:0]  req_q;
  logic [SW-1:0]       sel_q;

`ifdef SCARV_SOC_PERIPH_ROUTER_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  logic [15:0]         cnt_q;
`endif

  // Lowest matching slot wins, so scan from the top down.
  logic                hit;
  logic [SW-1:0]       hit_idx;
  logic [NUM_DEV-1:0]  hit_oh;
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_DEV - 1; i >= 0; i--) begin
      if ((h_addr & DEV_MASK[32*i +: 32]) == DEV_BASE[32*i +: 32]) begin
        hit     = 1'b1;
        hit_idx = SW'(i);
      end
    end
    hit_oh = NUM_DEV'(1) << hit_idx;
  end

  logic        sel_gnt, sel_recv, sel_err;
  logic [31:0] sel_rdata;
  always_comb begin
    sel_gnt   = 1'b0;
    sel_recv  = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (sel_q == SW'(i)) begin
        sel_gnt   = d_gnt[i];
        sel_recv  = d_recv[i];
        sel_err   = d_error[i];
        sel_rdata = d_rdata[32*i +: 32];
      end
    end
  end

  always_ff @(posedge f_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      live_q  <= 1'b0;
      recv_q  <= 1'b0;
      error_q <= 1'b0;
      rdata_q <= '0;
      wen_q   <= 1'b0;
      strb_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      req_q   <= '0;
      sel_q   <= '0;
`ifdef SCARV_SOC_PERIPH_ROUTER_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      live_q <= 1'b1;
      case (state_q)
        IDLE: begin
          gnt_q <= 1'b1;
          if (gnt_q && h_req) begin
            gnt_q   <= 1'b0;
            wen_q   <= h_wen;
            strb_q  <= h_strb;
            addr_q  <= h_addr;
            wdata_q <= h_wdata;
            sel_q   <= hit_idx;
            if (hit) begin
              state_q <= ISSUE;
              req_q   <= hit_oh;
`ifdef SCARV_SOC_PERIPH_ROUTER_TIMEOUT_EN
              cnt_q   <= '0;
`endif
            end else begin
              state_q <= RESP;
              recv_q  <= 1'b1;
              error_q <= 1'b1;
              rdata_q <= '0;
            end
          end
        end
        ISSUE: begin
          if (sel_gnt) begin
            state_q <= WAIT;
            req_q   <= '0;
`ifdef SCARV_SOC_PERIPH_ROUTER_TIMEOUT_EN
            cnt_q   <= '0;
          end else if (cnt_q == TO_LAST) begin
            state_q <= RESP;
            req_q   <= '0;
            recv_q  <= 1'b1;
            error_q <= 1'b1;
            rdata_q <= '0;
          end else begin
            cnt_q   <= cnt_q + 16'd1;
`endif
          end
        end
        WAIT: begin
          if (sel_recv) begin
            state_q <= RESP;
            recv_q  <= 1'b1;
            error_q <= sel_err;
            rdata_q <= sel_rdata;
`ifdef SCARV_SOC_PERIPH_ROUTER_TIMEOUT_EN
          end else if (cnt_q == TO_LAST) begin
            state_q <= RESP;
            recv_q  <= 1'b1;
            error_q <= 1'b1;
            rdata_q <= '0;
          end else begin
            cnt_q   <= cnt_q + 16'd1;
`endif
          end
        end
        RESP: begin
          if (h_ack) begin
            state_q <= IDLE;
            recv_q  <= 1'b0;
            gnt_q   <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign h_gnt   = gnt_q;
  assign h_recv  = recv_q;
  assign h_error = error_q;
  assign h_rdata = rdata_q;
  assign d_req   = req_q;
  assign d_wen   = wen_q;
  assign d_strb  = strb_q;
  assign d_addr  = addr_q;
  assign d_wdata = wdata_q;

  // Every response is accepted at once, including strays and late ones after an abort;
  // only the slot still being requested is held off until it has been granted.
  assign d_ack = d_recv & ~req_q & {NUM_DEV{live_q}};

endmodule

// File: tb/tb_scarv_soc_periph_router.sv
// Directed, table-driven bench for scarv_soc_periph_router (4 slots, TIMEOUT=8).
module tb_scarv_soc_periph_router;

  logic         f_clk = 1'b0;
  logic         g_resetn;
  logic         h_req, h_gnt, h_wen, h_recv, h_ack, h_error;
  logic [3:0]   h_strb;
  logic [31:0]  h_addr, h_wdata, h_rdata;
  logic [3:0]   d_req, d_gnt, d_recv, d_ack, d_error;
  logic         d_wen;
  logic [3:0]   d_strb;
  logic [31:0]  d_addr, d_wdata;
  logic [127:0] d_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 f_clk = ~f_clk;

  scarv_soc_periph_router #(.NUM_DEV(4), .TIMEOUT(8)) dut (
    .f_clk(f_clk), .g_resetn(g_resetn),
    .h_req(h_req), .h_gnt(h_gnt), .h_wen(h_wen), .h_strb(h_strb),
    .h_addr(h_addr), .h_wdata(h_wdata), .h_recv(h_recv), .h_ack(h_ack),
    .h_error(h_error), .h_rdata(h_rdata),
    .d_req(d_req), .d_gnt(d_gnt), .d_wen(d_wen), .d_strb(d_strb),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_recv(d_recv), .d_ack(d_ack),
    .d_error(d_error), .d_rdata(d_rdata)
  );

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          slot;
    int          gnt_dly;
    int          rsp_dly;
    logic [31:0] dev_rdata;
    logic        dev_err;
    int          ack_dly;
    logic [3:0]  exp_req;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tv [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clr_dev();
    d_gnt = '0; d_recv = '0; d_error = '0; d_rdata = '0;
  endtask

  task automatic start_req(input logic wen, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb);
    @(posedge f_clk); #1;
    h_req = 1'b1; h_wen = wen; h_addr = addr; h_wdata = wdata; h_strb = strb;
    @(negedge f_clk);
    chk("gnt_at_req", {31'b0, h_gnt}, 32'd1);
  endtask

  // One cycle of h_ack, then IDLE with h_gnt back the following cycle.
  task automatic ack_resp();
    @(posedge f_clk); #1;
    h_ack = 1'b1;
    @(posedge f_clk); #1;
    h_ack = 1'b0;
    @(negedge f_clk);
    chk("gnt_after_ack", {31'b0, h_gnt}, 32'd1);
    chk("recv_after_ack", {31'b0, h_recv}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int  c;
    bit  seen;
    start_req(v.wen, v.addr, v.wdata, v.strb);
    c = 0;
    seen = 1'b0;
    while (!seen && c < 40) begin
      @(posedge f_clk); #1;
      c++;
      h_req = 1'b0; h_wen = ~v.wen; h_addr = ~v.addr; h_wdata = ~v.wdata; h_strb = ~v.strb;
      clr_dev();
      if (v.slot >= 0 && c == 1 + v.gnt_dly) d_gnt[v.slot] = 1'b1;
      if (v.slot >= 0 && c == 2 + v.gnt_dly + v.rsp_dly) begin
        d_recv[v.slot]  = 1'b1;
        d_error[v.slot] = v.dev_err;
        d_rdata[32*v.slot +: 32] = v.dev_rdata;
      end
      @(negedge f_clk);
      if (c == 1) begin
        chk("d_req_first", {28'b0, d_req}, {28'b0, v.exp_req});
        if (v.exp_req != 4'b0) begin
          chk("d_addr", d_addr, v.addr);
          chk("d_wdata", d_wdata, v.wdata);
          chk("d_strb", {28'b0, d_strb}, {28'b0, v.strb});
          chk("d_wen", {31'b0, d_wen}, {31'b0, v.wen});
        end
      end
      chk("no_stray_req", {28'b0, d_req & ~v.exp_req}, 32'd0);
      if (v.slot >= 0 && c == 2 + v.gnt_dly + v.rsp_dly)
        chk("d_ack_sel", {28'b0, d_ack}, {28'b0, v.exp_req});
      seen = h_recv;
    end
    clr_dev();
    chk("latency", c, v.exp_lat);
    chk("h_rdata", h_rdata, v.exp_rdata);
    chk("h_error", {31'b0, h_error}, {31'b0, v.exp_err});
    chk("gnt_in_resp", {31'b0, h_gnt}, 32'd0);
    for (int k = 0; k < v.ack_dly; k++) begin
      @(posedge f_clk); #1;
      @(negedge f_clk);
      chk("hold_recv", {31'b0, h_recv}, 32'd1);
      chk("hold_rdata", h_rdata, v.exp_rdata);
      chk("hold_gnt", {31'b0, h_gnt}, 32'd0);
    end
    ack_resp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (limit 200000)");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    tv[0] = '{1'b0, 32'h1000_1004, 32'h0,          4'hF,    1, 0, 0, 32'hDEAD_BEEF, 1'b0, 5, 4'b0010, 3, 32'hDEAD_BEEF, 1'b0};
    tv[1] = '{1'b0, 32'h2000_0000, 32'h0,          4'hF,   -1, 0, 0, 32'h0,         1'b0, 0, 4'b0000, 1, 32'h0,         1'b1};
    tv[2] = '{1'b1, 32'h1000_3010, 32'h1234_5678, 4'b0011, 3, 2, 1, 32'h0,         1'b0, 1, 4'b1000, 6, 32'h0,         1'b0};
    tv[3] = '{1'b0, 32'h1000_0FFC, 32'h0,          4'hF,    0, 1, 0, 32'hA5A5_0001, 1'b1, 0, 4'b0001, 4, 32'hA5A5_0001, 1'b1};
    tv[4] = '{1'b0, 32'h1000_2000, 32'h0,          4'b1100, 2, 0, 3, 32'h0BAD_F00D, 1'b0, 2, 4'b0100, 6, 32'h0BAD_F00D, 1'b0};
    tv[5] = '{1'b1, 32'h1000_4000, 32'hFFFF_FFFF, 4'hF,   -1, 0, 0, 32'h0,         1'b0, 0, 4'b0000, 1, 32'h0,         1'b1};

    g_resetn = 1'b0;
    h_req = 1'b0; h_wen = 1'b0; h_strb = '0; h_addr = '0; h_wdata = '0; h_ack = 1'b0;
    clr_dev();
    d_recv = 4'b1111;
    repeat (3) @(posedge f_clk);
    @(negedge f_clk);
    chk("rst_h_gnt", {31'b0, h_gnt}, 32'd0);
    chk("rst_h_recv", {31'b0, h_recv}, 32'd0);
    chk("rst_h_error", {31'b0, h_error}, 32'd0);
    chk("rst_h_rdata", h_rdata, 32'd0);
    chk("rst_d_req", {28'b0, d_req}, 32'd0);
    chk("rst_d_ack", {28'b0, d_ack}, 32'd0);
    chk("rst_d_addr", d_addr, 32'd0);
    chk("rst_d_wdata", d_wdata, 32'd0);
    chk("rst_d_strb_wen", {27'b0, d_strb, d_wen}, 32'd0);
    d_recv = '0;
    g_resetn = 1'b1;
    @(negedge f_clk);
    chk("post_rst_gnt", {31'b0, h_gnt}, 32'd1);

    for (int i = 0; i < 6; i++) run_vec(tv[i]);

    // Non-selected grant ignored, stray responses drained during WAIT.
    start_req(1'b0, 32'h1000_1000, 32'h0, 4'hF);
    @(posedge f_clk); #1; h_req = 1'b0; clr_dev(); d_gnt = 4'b1000;
    @(negedge f_clk); chk("drain_issue_req", {28'b0, d_req}, 32'h2);
    @(posedge f_clk); #1; clr_dev(); d_gnt = 4'b0010;
    @(negedge f_clk); chk("drain_gnt_req", {28'b0, d_req}, 32'h2);
    @(posedge f_clk); #1; clr_dev(); d_recv = 4'b0101; d_rdata = {4{32'hBAAD_BAAD}};
    @(negedge f_clk);
    chk("drain_ack", {28'b0, d_ack}, 32'h5);
    chk("drain_req_low", {28'b0, d_req}, 32'h0);
    @(posedge f_clk); #1; clr_dev();
    @(negedge f_clk); chk("drain_no_recv", {31'b0, h_recv}, 32'd0);
    @(posedge f_clk); #1; clr_dev(); d_recv = 4'b0010; d_rdata[63:32] = 32'h5555_AAAA;
    @(negedge f_clk); chk("drain_sel_ack", {28'b0, d_ack}, 32'h2);
    @(posedge f_clk); #1; clr_dev();
    @(negedge f_clk);
    chk("drain_recv", {31'b0, h_recv}, 32'd1);
    chk("drain_rdata", h_rdata, 32'h5555_AAAA);
    chk("drain_err", {31'b0, h_error}, 32'd0);
    ack_resp();

    // Reset asserted in WAIT while the device is presenting a response.
    start_req(1'b0, 32'h1000_1000, 32'h0, 4'hF);
    @(posedge f_clk); #1; h_req = 1'b0; clr_dev(); d_gnt = 4'b0010;
    @(posedge f_clk); #1; clr_dev(); d_recv = 4'b0010;
    #1; chk("wait_ack_pre_rst", {28'b0, d_ack}, 32'h2);
    g_resetn = 1'b0;
    #1;
    chk("mid_rst_recv", {31'b0, h_recv}, 32'd0);
    chk("mid_rst_req", {28'b0, d_req}, 32'd0);
    chk("mid_rst_ack", {28'b0, d_ack}, 32'd0);
    chk("mid_rst_gnt", {31'b0, h_gnt}, 32'd0);
    clr_dev();
    @(negedge f_clk); g_resetn = 1'b1;
    @(negedge f_clk);
    v = tv[0];
    v.ack_dly = 0;
    run_vec(v);

`ifdef SCARV_SOC_PERIPH_ROUTER_TIMEOUT_EN
    begin
      int c;
      start_req(1'b0, 32'h1000_0000, 32'h0, 4'hF);
      c = 0;
      while (h_recv !== 1'b1 && c < 40) begin
        @(posedge f_clk); #1; c++; h_req = 1'b0; clr_dev();
        @(negedge f_clk);
        if (c == 8) chk("to_req_held", {28'b0, d_req}, 32'h1);
      end
      chk("to_latency", c, 9);
      chk("to_error", {31'b0, h_error}, 32'd1);
      chk("to_rdata", h_rdata, 32'd0);
      chk("to_req_drop", {28'b0, d_req}, 32'd0);
      ack_resp();
      @(posedge f_clk); #1; d_recv = 4'b0001; d_rdata[31:0] = 32'h7777_7777;
      @(negedge f_clk); chk("to_late_ack", {28'b0, d_ack}, 32'h1);
      @(posedge f_clk); #1; clr_dev();
      @(negedge f_clk);
      chk("to_late_no_recv", {31'b0, h_recv}, 32'd0);
      chk("to_late_gnt", {31'b0, h_gnt}, 32'd1);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
